// File: rtl/sync_fifo_stream_reader_pkg.sv
// Shared types and sizing for the FIFO read-side stream engine.
// The output buffer depth sets every counter and pointer width derived here.
package sync_fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 32;
  localparam int unsigned SKID_DEPTH         = 2;
  localparam int unsigned SKID_CNT_WIDTH     = $clog2(SKID_DEPTH + 1);
  localparam int unsigned SKID_PTR_WIDTH     = $clog2(SKID_DEPTH);
  localparam int unsigned OCC_WIDTH          = SKID_CNT_WIDTH + 1;

  typedef enum logic {
    REGISTERED   = 1'b0,
    FALL_THROUGH = 1'b1
  } fwft_mode_t;

  // True when a new read still fits once buffered, in-flight and departing words are counted.
  function automatic logic room_for_read(
    input logic [SKID_CNT_WIDTH-1:0] count,
    input logic                      inflight,
    input logic                      pop
  );
    logic [OCC_WIDTH-1:0] committed;
    committed = OCC_WIDTH'(count) + OCC_WIDTH'(inflight);
    return committed < (OCC_WIDTH'(SKID_DEPTH) + OCC_WIDTH'(pop));
  endfunction

endpackage

// File: rtl/sync_fifo_stream_reader_skid.sv
// Two-entry circular output buffer; head entry drives the stream data from registers.
// Simultaneous push and pop keep the count and advance both pointers.
module stream_skid_buffer
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      push,
  input  logic [DATA_WIDTH-1:0]     push_data,
  input  logic                      pop,
  output logic [SKID_CNT_WIDTH-1:0] count,
  output logic [DATA_WIDTH-1:0]     head_data
);

  logic [DATA_WIDTH-1:0]     entry_q [SKID_DEPTH];
  logic [SKID_PTR_WIDTH-1:0] rd_ptr_q;
  logic [SKID_PTR_WIDTH-1:0] wr_ptr_q;
  logic [SKID_CNT_WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + SKID_PTR_WIDTH'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + SKID_PTR_WIDTH'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + SKID_CNT_WIDTH'(1);
        2'b01:   count_q <= count_q - SKID_CNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SKID_DEPTH); i++) entry_q[i] <= '0;
    end else if (push && !clear) begin
      entry_q[wr_ptr_q] <= push_data;
    end
  end

  assign count     = count_q;
  assign head_data = entry_q[rd_ptr_q];

  // Issue logic must never let a capture land on a full buffer without a matching pop.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !clear && (count_q == SKID_CNT_WIDTH'(SKID_DEPTH))));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (count_q == '0)));
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= SKID_CNT_WIDTH'(SKID_DEPTH));

endmodule

// File: rtl/sync_fifo_stream_reader.sv
// Drains a synchronous FIFO read port into a valid/ready stream at one word per cycle.
// Reads are issued against buffer occupancy plus the word still in flight from the FIFO.
module sync_fifo_stream_reader
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter bit          FWFT       = 1'b0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_rd_o,
  input  logic                  flush_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic [CNT_WIDTH-1:0]  xfer_cnt_o
);

  localparam fwft_mode_t MODE = fwft_mode_t'(FWFT);

  logic [SKID_CNT_WIDTH-1:0] count;
  logic [DATA_WIDTH-1:0]     head_data;
  logic                      pop;
  logic                      inflight;
  logic                      capture;
  logic                      flush_discard;
  logic                      push;
  logic [CNT_WIDTH-1:0]      xfer_cnt_q;

  // Registered FIFO returns data a cycle after the strobe; fall-through returns it immediately.
  generate
    if (MODE == REGISTERED) begin : g_registered
      logic inflight_q;

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) inflight_q <= 1'b0;
        else          inflight_q <= fifo_rd_o;
      end

      assign inflight = inflight_q;
      assign capture  = inflight_q;
    end else begin : g_fall_through
      assign inflight = 1'b0;
      assign capture  = fifo_rd_o;
    end
  endgenerate

  // Stream handshake and read issue; reset forces the strobe low without waiting for an edge.
  always_comb begin
    m_valid_o = (count != '0) && !flush_i;
    pop       = m_valid_o && m_ready_i;
    fifo_rd_o = rst_n_i && !fifo_empty_i && !flush_i && room_for_read(count, inflight, pop);
  end

  // A word returning while flush is high belongs to the discarded stream.
  always_comb begin
    flush_discard = capture && flush_i;
    push          = capture && !flush_discard;
  end

  stream_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .clear     (flush_i),
    .push      (push),
    .push_data (fifo_data_i),
    .pop       (pop),
    .count     (count),
    .head_data (head_data)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  xfer_cnt_q <= '0;
    else if (pop)  xfer_cnt_q <= xfer_cnt_q + CNT_WIDTH'(1);
  end

  assign m_data_o   = head_data;
  assign xfer_cnt_o = xfer_cnt_q;

  a_rd_not_empty: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(fifo_rd_o && fifo_empty_i));

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// Bench for sync_fifo_stream_reader: lane 0 is a registered-read FIFO with a 4-bit counter,
// lane 1 a fall-through FIFO; both are scored against a words-outstanding reference model.
module tb_sync_fifo_stream_reader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        empty0, rd0, flush0, valid0, ready0;
  logic [31:0] data0, mdata0;
  logic [3:0]  cnt0;
  logic        empty1, rd1, flush1, valid1, ready1;
  logic [31:0] data1, mdata1;
  logic [15:0] cnt1;

  sync_fifo_stream_reader #(.DATA_WIDTH(32), .FWFT(1'b0), .CNT_WIDTH(4)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .fifo_empty_i(empty0), .fifo_data_i(data0),
    .fifo_rd_o(rd0), .flush_i(flush0), .m_valid_o(valid0), .m_ready_i(ready0),
    .m_data_o(mdata0), .xfer_cnt_o(cnt0));

  sync_fifo_stream_reader #(.DATA_WIDTH(32), .FWFT(1'b1), .CNT_WIDTH(16)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .fifo_empty_i(empty1), .fifo_data_i(data1),
    .fifo_rd_o(rd1), .flush_i(flush1), .m_valid_o(valid1), .m_ready_i(ready1),
    .m_data_o(mdata1), .xfer_cnt_o(cnt1));

  logic [31:0] fifoq    [2][$];
  logic [31:0] pend     [2][$];
  int          pend_cyc [2][$];
  logic [31:0] got      [2][$];
  int unsigned hs [2];
  int          lat [2];
  logic        stall_q [2];
  logic [31:0] stall_d [2];
  int          first_rd [2], first_valid [2], last_hs [2], rd_pulses [2];
  logic [31:0] fwft0_data_q;
  int          cyc;
  int          errors, checks;

  task automatic chk(input string tag, input int l, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s lane%0d: observed=%0h expected=%0h", tag, l, obs, exp);
    end
  endtask

  task automatic refresh_fifo();
    empty0 = (fifoq[0].size() == 0);
    data0  = fwft0_data_q;
    empty1 = (fifoq[1].size() == 0);
    data1  = empty1 ? 32'h0 : fifoq[1][0];
  endtask

  task automatic reset_trk(input int l);
    first_rd[l] = -1; first_valid[l] = -1; last_hs[l] = -1; rd_pulses[l] = 0;
    got[l].delete();
  endtask

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      pend[l].delete(); pend_cyc[l].delete();
      hs[l] = 0; stall_q[l] = 1'b0;
    end
  endtask

  // Scores one lane for the cycle about to end: handshake data, valid timing, read decisions.
  task automatic check_lane(input int l, input logic v, input logic r, input logic rd,
                            input logic fl, input logic [31:0] d, input logic [15:0] cnt,
                            input logic [15:0] mask);
    logic [31:0] exp;
    logic        exp_v, exp_rd;
    chk("xfer_cnt", l, 32'(cnt), hs[l] & 32'(mask));
    exp_v = !fl && (pend[l].size() != 0) && ((cyc - pend_cyc[l][0]) >= lat[l]);
    chk("valid", l, 32'(v), 32'(exp_v));
    if (stall_q[l] && !fl && rst_n) chk("hold_data", l, d, stall_d[l]);
    if (v && r) begin
      chk("hs_has_word", l, 32'(pend[l].size() != 0), 32'd1);
      if (pend[l].size() != 0) begin
        exp = pend[l].pop_front();
        void'(pend_cyc[l].pop_front());
        chk("hs_data", l, d, exp);
      end
      got[l].push_back(d);
      hs[l]++;
      last_hs[l] = cyc;
    end
    if (fl) begin
      pend[l].delete(); pend_cyc[l].delete();
    end
    exp_rd = rst_n && !fl && (fifoq[l].size() != 0) && (pend[l].size() < 2);
    chk("rd", l, 32'(rd), 32'(exp_rd));
    if (rd && fifoq[l].size() != 0) begin
      pend[l].push_back(fifoq[l][0]);
      pend_cyc[l].push_back(cyc);
      rd_pulses[l]++;
      if (first_rd[l] < 0) first_rd[l] = cyc;
    end
    if (v && first_valid[l] < 0) first_valid[l] = cyc;
    stall_q[l] = v && !r;
    stall_d[l] = d;
  endtask

  // One clock: inputs are set at the negedge, outputs scored just after, FIFO pops after the edge.
  task automatic step();
    logic r0, r1;
    #1;
    r0 = rd0; r1 = rd1;
    check_lane(0, valid0, ready0, rd0, flush0, mdata0, 16'(cnt0), 16'h000F);
    check_lane(1, valid1, ready1, rd1, flush1, mdata1, cnt1, 16'hFFFF);
    @(posedge clk);
    #1;
    if (r0 && fifoq[0].size() != 0) fwft0_data_q = fifoq[0].pop_front();
    if (r1 && fifoq[1].size() != 0) void'(fifoq[1].pop_front());
    refresh_fifo();
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    logic done;
    ready0 = 1'b1; ready1 = 1'b1; flush0 = 1'b0; flush1 = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      done = (fifoq[0].size() == 0) && (fifoq[1].size() == 0) &&
             (pend[0].size() == 0) && (pend[1].size() == 0);
    end
    chk("drain_done", 0, 32'(done), 32'd1);
  endtask

  initial begin
    logic [31:0] saved;
    errors = 0; checks = 0; cyc = 0;
    lat[0] = 2; lat[1] = 1;
    fwft0_data_q = 32'h0;
    rst_n = 1'b0;
    ready0 = 1'b0; ready1 = 1'b0; flush0 = 1'b0; flush1 = 1'b0;
    model_reset();
    reset_trk(0); reset_trk(1);
    refresh_fifo();
    #2;
    chk("rst_valid", 0, 32'(valid0), 32'd0);
    chk("rst_rd",    0, 32'(rd0),    32'd0);
    chk("rst_data",  0, mdata0,      32'd0);
    chk("rst_cnt",   0, 32'(cnt0),   32'd0);
    chk("rst_valid", 1, 32'(valid1), 32'd0);
    chk("rst_cnt",   1, 32'(cnt1),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Registered FIFO, free-flowing stream.
    reset_trk(0);
    for (int i = 1; i <= 8; i++) fifoq[0].push_back(32'(i));
    refresh_fifo();
    ready0 = 1'b1;
    repeat (14) step();
    chk("t1_latency", 0, 32'(first_valid[0] - first_rd[0]), 32'd2);
    chk("t1_burst",   0, 32'(last_hs[0] - first_valid[0]), 32'd7);
    chk("t1_count",   0, 32'(got[0].size()), 32'd8);
    for (int i = 0; i < 8 && i < got[0].size(); i++) chk("t1_order", 0, got[0][i], 32'(i + 1));
    chk("t1_xfer",    0, 32'(cnt0), 32'd8);
    chk("t1_rd_idle", 0, 32'(rd0),  32'd0);

    // Fall-through FIFO, free-flowing stream.
    reset_trk(1);
    for (int i = 1; i <= 8; i++) fifoq[1].push_back(32'(i));
    refresh_fifo();
    ready1 = 1'b1;
    repeat (12) step();
    chk("t2_latency", 1, 32'(first_valid[1] - first_rd[1]), 32'd1);
    chk("t2_burst",   1, 32'(last_hs[1] - first_valid[1]), 32'd7);
    chk("t2_count",   1, 32'(got[1].size()), 32'd8);
    for (int i = 0; i < 8 && i < got[1].size(); i++) chk("t2_order", 1, got[1][i], 32'(i + 1));
    chk("t2_xfer",    1, 32'(cnt1), 32'd8);

    // Backpressure: stream stalled ten cycles.
    ready0 = 1'b0; ready1 = 1'b0;
    reset_trk(0);
    for (int i = 0; i < 6; i++) fifoq[0].push_back(32'hA0 + 32'(i));
    refresh_fifo();
    repeat (10) step();
    chk("t3_rd_pulses", 0, 32'(rd_pulses[0]), 32'd2);
    chk("t3_held_valid", 0, 32'(valid0), 32'd1);
    chk("t3_held_data", 0, mdata0, 32'hA0);
    ready0 = 1'b1;
    repeat (10) step();
    chk("t3_count", 0, 32'(got[0].size()), 32'd6);
    for (int i = 0; i < 6 && i < got[0].size(); i++) chk("t3_order", 0, got[0][i], 32'hA0 + 32'(i));

    // Flush with one word buffered and one in flight.
    reset_trk(0);
    for (int i = 0; i < 8; i++) fifoq[0].push_back(32'hB0 + 32'(i));
    refresh_fifo();
    ready0 = 1'b1;
    repeat (4) step();
    saved = 32'(cnt0);
    flush0 = 1'b1;
    step();
    flush0 = 1'b0;
    chk("t4_xfer_hold", 0, 32'(cnt0), saved);
    chk("t4_before", 0, 32'(got[0].size()), 32'd2);
    for (int i = 0; i < 10 && got[0].size() < 3; i++) step();
    chk("t4_resume_seen", 0, 32'(got[0].size() >= 3), 32'd1);
    if (got[0].size() >= 3) chk("t4_next_word", 0, got[0][2], 32'hB4);
    drain();
    chk("t4_total", 0, 32'(got[0].size()), 32'd6);

    // Asynchronous reset with the buffer full.
    reset_trk(0);
    ready0 = 1'b0;
    for (int i = 0; i < 6; i++) fifoq[0].push_back(32'hC0 + 32'(i));
    refresh_fifo();
    repeat (4) step();
    chk("t5_full_valid", 0, 32'(valid0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 0, 32'(valid0), 32'd0);
    chk("t5_rst_rd",    0, 32'(rd0),    32'd0);
    chk("t5_rst_cnt",   0, 32'(cnt0),   32'd0);
    chk("t5_rst_cnt",   1, 32'(cnt1),   32'd0);
    model_reset();
    step();
    rst_n = 1'b1;
    reset_trk(0);
    drain();
    chk("t5_count", 0, 32'(got[0].size()), 32'd4);
    if (got[0].size() != 0) chk("t5_head", 0, got[0][0], 32'hC2);

    // Counter wrap on the 4-bit lane.
    rst_n = 1'b0;
    model_reset();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) fifoq[0].push_back(32'hD00 + 32'(i));
    refresh_fifo();
    drain();
    chk("t6_wrap", 0, 32'(cnt0), 32'd1);

    // Random traffic on both lanes.
    for (int i = 0; i < 1500; i++) begin
      ready0 = ($urandom_range(0, 3) != 0);
      ready1 = ($urandom_range(0, 3) != 0);
      flush0 = ($urandom_range(0, 49) == 0);
      flush1 = ($urandom_range(0, 49) == 0);
      if (fifoq[0].size() < 12 && $urandom_range(0, 1) == 1) fifoq[0].push_back($urandom);
      if (fifoq[1].size() < 12 && $urandom_range(0, 1) == 1) fifoq[1].push_back($urandom);
      refresh_fifo();
      step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
